fsk_frame_sched: RTL
====================

// Module: fsk_frame_sched
// PURPOSE
//  Frame scheduler driving the FSK modulator's fsk_base_data bit input.
//  Accepts a frame request plus a byte stream (valid/ready) and emits a timed bit sequence:
//   preamble -> sync word -> payload bytes (LSB first) -> mark gap.
//  Each bit is held for exactly SAMPLES_PER_BIT clocks, so the phase-continuous NCO sees a clean symbol rate.
// PARAMETERS
//  SAMPLES_PER_BIT  1200   clocks per symbol (100 kbit/s at 120 MHz); legal range >= 2
//  PREAMBLE_BITS    16     alternating bits, first bit 1
//  SYNC_WORD        8'hD3  sync byte, sent LSB first
//  GAP_BITS         8      trailing mark (1) bits after the payload
// PORTS
//  clk            in   1   system clock, same clock as the modulator
//  rst            in   1   synchronous, active-low reset
//  frame_start    in   1   one-cycle request; sampled only in IDLE
//  frame_len      in   8   payload byte count, latched with frame_start; 0 is legal
//  in_data        in   8   payload byte
//  in_valid       in   1   in_data valid
//  in_ready       out  1   byte accepted when in_valid & in_ready
//  fsk_base_data  out  1   bit to the modulator; idle level 1 (mark)
//  tx_busy        out  1   high in every state except IDLE
//  frame_done     out  1   one-cycle pulse on the last clock of GAP
//  underrun       out  1   one-cycle pulse when a payload byte is missing at its boundary
// BEHAVIOUR
//  Reset
//   - FSM to IDLE; fsk_base_data=1, in_ready=0, tx_busy=0, frame_done=0, underrun=0.
//   - Timer, bit index, byte count and holding register are cleared.
//   - A reset in any state aborts the frame immediately; there is no done pulse.
//  FSM: IDLE -> PREAMBLE -> SYNC -> DATA -> GAP -> IDLE
//   - IDLE: frame_start=1 at edge t latches frame_len. PREAMBLE bit 0 (value 1) appears at t+1.
//   - frame_start outside IDLE is ignored.
//   - PREAMBLE: PREAMBLE_BITS symbols; bit k = ~k[0].
//   - SYNC: 8 symbols of SYNC_WORD, LSB first. Then DATA, or GAP directly if frame_len==0.
//   - DATA: frame_len bytes, each 8 symbols LSB first.
//   - GAP: GAP_BITS symbols of 1. frame_done pulses on the final clock, then IDLE.
//  Symbol timing
//   - The timer counts 0..SAMPLES_PER_BIT-1. fsk_base_data is registered and changes only when the timer wraps.
//   - Every symbol is exactly SAMPLES_PER_BIT clocks, with no gaps between states.
//  Byte handshake
//   - One holding register. in_ready = ~hold_full while in SYNC or DATA and bytes remain unaccepted.
//   - The holding register moves to the shift register at the byte boundary, so the next byte may be accepted during the current byte.
//   - Simultaneous accept and boundary transfer are both honoured in the same cycle.
//  Underrun
//   - If hold_full==0 at a DATA byte boundary, underrun pulses and the FSM jumps to GAP.
//   - The rest of the frame is dropped and frame_done still pulses at the end of GAP.
//   - Only frame_len bytes are accepted; in_ready is 0 after the last one.
//  Widths: the timer is $clog2(SAMPLES_PER_BIT) bits; the byte counter is 8 bits and counts down to 0 without wrapping.
// CONFIGURATION
//  FSK_PARITY_EN defined
//   - Each payload byte is followed by a 9th symbol: even parity (^byte).
//   - The byte boundary moves to the end of that symbol.
//  FSK_PARITY_EN undefined: 8 symbols per byte, no parity logic.
// STRUCTURE
//  - fsk_pkg: state enum (IDLE, PREAMBLE, SYNC, DATA, GAP), MARK_BIT=1'b1, BITS_PER_BYTE derived from FSK_PARITY_EN.
//  - Sub-module fsk_bit_timer: parameterised wrap counter with a sym_tick output. Synchronous clear is driven by rst and by IDLE.
// TESTING (SAMPLES_PER_BIT=4, PREAMBLE_BITS=4, SYNC_WORD=8'hD3, GAP_BITS=2)
//  - Idle/reset: hold rst=0 for 5 clks -> fsk_base_data=1 and all other outputs 0. Release -> stays IDLE.
//  - frame_len=1, byte 8'hA5 pre-supplied -> bits 1010 | 11001011 | 10100101 | 11, each 4 clks.
//    frame_done is high only on clk 4*22 after the start edge.
//  - frame_len=0 -> preamble + sync + gap (14 symbols = 56 clks), then frame_done; in_ready never asserts.
//  - frame_len=2, second byte withheld -> underrun pulses at the boundary after byte 1, 2 gap symbols follow, then frame_done.
//  - frame_start pulsed mid-frame, and in_valid held high after the last byte -> no effect, exactly frame_len handshakes.
//  - rst=0 during DATA -> next clk fsk_base_data=1, tx_busy=0, no frame_done.
//    With FSK_PARITY_EN: byte 8'h07 is followed by parity symbol 1.

Source files
------------

// File: rtl/fsk_pkg.sv
// rtl/fsk_pkg.sv - shared types and constants for the FSK frame scheduler (FSK_PARITY_EN adds a parity symbol per byte)
package fsk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        DATA,
        GAP
    } state_e;

    localparam logic MARK_BIT = 1'b1;

`ifdef FSK_PARITY_EN
    localparam int BITS_PER_BYTE = 9;
`else
    localparam int BITS_PER_BYTE = 8;
`endif

    // Symbol value for position idx within a payload byte (LSB first);
    // position 8 is the even-parity symbol when parity is enabled.
    function automatic logic byte_bit(input logic [7:0] b, input logic [3:0] idx);
`ifdef FSK_PARITY_EN
        return idx[3] ? ^b : b[idx[2:0]];
`else
        return idx[3] ? MARK_BIT : b[idx[2:0]];
`endif
    endfunction

endpackage

// File: rtl/fsk_bit_timer.sv
// rtl/fsk_bit_timer.sv - symbol timer wrapping every SAMPLES_PER_BIT clocks
module fsk_bit_timer #(
    parameter int SAMPLES_PER_BIT = 1200
) (
    input  logic clk,
    input  logic clr_i,
    output logic sym_tick_o
);

    localparam int CW = $clog2(SAMPLES_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(SAMPLES_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Tick marks the final clock of the current symbol.
    assign sym_tick_o = (count_q == LAST);

    // Next count: cleared while idle or in reset, wraps at the end of a symbol.
    always_comb begin
        count_d = count_q + CW'(1);
        if (clr_i || sym_tick_o) begin
            count_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

endmodule

// File: rtl/fsk_frame_sched.sv
// rtl/fsk_frame_sched.sv - frame scheduler driving fsk_base_data (FSK_PARITY_EN adds byte parity)
module fsk_frame_sched
    import fsk_pkg::*;
#(
    parameter int         SAMPLES_PER_BIT = 1200,
    parameter int         PREAMBLE_BITS   = 16,
    parameter logic [7:0] SYNC_WORD       = 8'hD3,
    parameter int         GAP_BITS        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic [7:0] frame_len,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       fsk_base_data,
    output logic       tx_busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_BITS - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_BITS - 1);
    localparam logic [7:0] BYTE_LAST = 8'(BITS_PER_BYTE - 1);

    state_e     state_q, state_d;
    logic [7:0] bit_idx_q, bit_idx_d;
    logic [7:0] left_q, left_d;       // bytes still to be accepted
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] shift_q, shift_d;
    logic       out_q, out_d;

    logic       sym_tick;
    logic       accept;
    logic       byte_boundary;
    logic [7:0] nidx;

    fsk_bit_timer #(
        .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
    ) u_timer (
        .clk       (clk),
        .clr_i     (!rst || (state_q == IDLE)),
        .sym_tick_o(sym_tick)
    );

    assign nidx          = bit_idx_q + 8'd1;
    assign in_ready      = !hold_full_q && ((state_q == SYNC) || (state_q == DATA)) && (left_q != 8'd0);
    assign accept        = in_valid && in_ready;
    assign byte_boundary = sym_tick && (((state_q == SYNC) && (bit_idx_q == 8'd7)) ||
                                        ((state_q == DATA) && (bit_idx_q == BYTE_LAST)));
    assign underrun      = byte_boundary && !hold_full_q && (left_q != 8'd0);
    assign frame_done    = sym_tick && (state_q == GAP) && (bit_idx_q == GAP_LAST);
    assign tx_busy       = (state_q != IDLE);
    assign fsk_base_data = out_q;

    // Next-state logic: symbol sequencing on timer wraps plus the byte handshake.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        left_d      = left_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        out_d       = out_q;

        unique case (state_q)
            IDLE: begin
                hold_full_d = 1'b0;
                bit_idx_d   = 8'd0;
                out_d       = MARK_BIT;
                if (frame_start) begin
                    state_d = PREAMBLE;
                    left_d  = frame_len;
                    out_d   = 1'b1;
                end
            end
            PREAMBLE: begin
                if (sym_tick) begin
                    if (bit_idx_q == PRE_LAST) begin
                        state_d   = SYNC;
                        bit_idx_d = 8'd0;
                        out_d     = SYNC_WORD[0];
                    end else begin
                        bit_idx_d = nidx;
                        out_d     = ~nidx[0];
                    end
                end
            end
            SYNC, DATA: begin
                if (byte_boundary) begin
                    bit_idx_d = 8'd0;
                    if (hold_full_q) begin
                        state_d     = DATA;
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        out_d       = hold_q[0];
                    end else begin
                        // Either every byte is sent or one is missing: close the frame.
                        state_d = GAP;
                        out_d   = MARK_BIT;
                    end
                end else if (sym_tick) begin
                    bit_idx_d = nidx;
                    out_d     = (state_q == SYNC) ? SYNC_WORD[nidx[2:0]] : byte_bit(shift_q, nidx[3:0]);
                end
            end
            GAP: begin
                if (sym_tick) begin
                    out_d = MARK_BIT;
                    if (bit_idx_q == GAP_LAST) begin
                        state_d   = IDLE;
                        bit_idx_d = 8'd0;
                    end else begin
                        bit_idx_d = nidx;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Applied after the boundary transfer so both take effect in one cycle.
        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
            left_d      = left_q - 8'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_idx_q   <= 8'd0;
            left_q      <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            shift_q     <= 8'd0;
            out_q       <= MARK_BIT;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            left_q      <= left_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            out_q       <= out_d;
        end
    end

endmodule
